// File: rtl/conv_pkg.sv
// Shared types and parameter bounds for the convolution sequence controller.
package conv_pkg;

   typedef enum logic [3:0] {
      IDLE,
      IF_WAIT,
      IF_WR,
      KW_WAIT,
      KW_WR,
      CALC,
      DRAIN,
      READ,
      DONE
   } state_t;

   localparam int N_IF_MAX     = 4;
   localparam int N_KW_MAX     = 8;
   localparam int PIPE_LAT_MAX = 8;

   // Bank index must cover the larger of the two bank counts.
   localparam int BIDX_W  = $clog2(N_KW_MAX);
   localparam int DRAIN_W = $clog2(PIPE_LAT_MAX);

endpackage

// File: rtl/conv_lat_pipe.sv
// Delay line that tracks the calculation-active flag through the datapath latency.
module conv_lat_pipe #(
   parameter int LAT = 3
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic din,
   output logic tap_pre,
   output logic tap_last
);

   logic [LAT:1] d;
   logic [LAT:0] taps;

   assign taps = {d, din};

   always_ff @(posedge clk) begin
      if (rst || clr) begin
         d <= '0;
      end else begin
         d <= taps[LAT-1:0];
      end
   end

   assign tap_pre  = taps[LAT-1];
   assign tap_last = taps[LAT];

endmodule

// File: rtl/conv_seq_ctrl.sv
// Frame sequencer: ifmap bank loads, kernel bank loads (optionally reused),
// calculation, datapath drain and result readout.
module conv_seq_ctrl
   import conv_pkg::*;
#(
   parameter int N_IF     = 2,
   parameter int N_KW     = 4,
   parameter int PIPE_LAT = 3,
   parameter int CNT_W    = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_st_ifmd,
   input  logic             ifmd_wr_done,
   input  logic             in_st_kw,
   input  logic             kw_is_5_5,
   input  logic             kw_wr_done,
   input  logic             calc_done,
   input  logic             ofmd_rd_done,
   input  logic             abort,
   input  logic             keep_kw,
   output logic [N_IF-1:0]  ifmd_ram_en,
   output logic [N_IF-1:0]  ifmd_wr,
   output logic [N_KW-1:0]  kw_ram_en,
   output logic [N_KW-1:0]  kw_wr,
   output logic             is_5x5,
   output logic             rd_enable,
   output logic             ofmd_wr_addr_en,
   output logic             ofmd_ram_en,
   output logic             ofmd_rd_en,
   output logic             out_st,
   output logic             ifmd_wr_state,
   output logic             kw_wr_state,
   output logic             busy,
   output logic [CNT_W-1:0] frame_cnt,
   output logic             err_proto
);

   state_t              state, next_state;
   logic [BIDX_W-1:0]   bidx, next_bidx;
   logic [DRAIN_W-1:0]  drain_cnt;
   logic                kw_valid, keep_kw_q, set_kw_valid;
   logic                drain_last, calc_ing, proto_err;
   logic                lat_pre, lat_last;

   assign calc_ing   = (state == CALC);
   assign drain_last = (state == DRAIN) && (drain_cnt == DRAIN_W'(PIPE_LAT - 1));
   assign proto_err  = (in_st_ifmd || in_st_kw) &&
                       (state inside {IF_WR, KW_WR, CALC, DRAIN, READ});

   // Abort returns to IDLE but deliberately keeps frame_cnt and the latched kernel size.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         bidx      <= '0;
         drain_cnt <= '0;
         kw_valid  <= 1'b0;
         keep_kw_q <= 1'b0;
         is_5x5    <= 1'b0;
         out_st    <= 1'b0;
         frame_cnt <= '0;
         err_proto <= 1'b0;
      end else if (abort) begin
         state     <= IDLE;
         bidx      <= '0;
         drain_cnt <= '0;
         kw_valid  <= 1'b0;
         keep_kw_q <= 1'b0;
         out_st    <= 1'b0;
         err_proto <= 1'b0;
      end else begin
         state     <= next_state;
         bidx      <= next_bidx;
         drain_cnt <= (state == DRAIN) ? drain_cnt + 1'b1 : '0;
         out_st    <= drain_last;
         if (set_kw_valid) kw_valid <= 1'b1;
         if (state == DONE) begin
            keep_kw_q <= keep_kw;
            frame_cnt <= frame_cnt + CNT_W'(1);
         end
         if (state == KW_WAIT && bidx == '0 && in_st_kw) is_5x5 <= kw_is_5_5;
         if (proto_err) err_proto <= 1'b1;
      end
   end

   // Done strobes are only honoured in their own state, so a coincident start cannot double-advance.
   always_comb begin
      next_state   = state;
      next_bidx    = bidx;
      set_kw_valid = 1'b0;
      case (state)
         IDLE: begin
            if (in_st_ifmd) begin
               next_state = IF_WR;
               next_bidx  = '0;
            end
         end
         IF_WAIT: begin
            if (in_st_ifmd) next_state = IF_WR;
         end
         IF_WR: begin
            if (ifmd_wr_done) begin
               if (bidx < BIDX_W'(N_IF - 1)) begin
                  next_state = IF_WAIT;
                  next_bidx  = bidx + 1'b1;
               end else begin
                  next_bidx  = '0;
                  next_state = (kw_valid && keep_kw_q) ? CALC : KW_WAIT;
               end
            end
         end
         KW_WAIT: begin
            if (in_st_kw) next_state = KW_WR;
         end
         KW_WR: begin
            if (kw_wr_done) begin
               if (bidx < BIDX_W'(N_KW - 1)) begin
                  next_state = KW_WAIT;
                  next_bidx  = bidx + 1'b1;
               end else begin
                  next_state   = CALC;
                  next_bidx    = '0;
                  set_kw_valid = 1'b1;
               end
            end
         end
         CALC: begin
            if (calc_done) next_state = DRAIN;
         end
         DRAIN: begin
            if (drain_last) next_state = READ;
         end
         READ: begin
            if (ofmd_rd_done) next_state = DONE;
         end
         DONE: begin
            next_state = IF_WAIT;
            next_bidx  = '0;
         end
         default: begin
            next_state = IDLE;
            next_bidx  = '0;
         end
      endcase
   end

   always_comb begin
      ifmd_wr = '0;
      kw_wr   = '0;
      for (int i = 0; i < N_IF; i++) ifmd_wr[i] = (state == IF_WR) && (bidx == BIDX_W'(i));
      for (int i = 0; i < N_KW; i++) kw_wr[i] = (state == KW_WR) && (bidx == BIDX_W'(i));
      ifmd_ram_en = ifmd_wr | {N_IF{calc_ing}};
      kw_ram_en   = kw_wr | {N_KW{calc_ing}};
   end

   conv_lat_pipe #(
      .LAT (PIPE_LAT)
   ) u_lat_pipe (
      .clk      (clk),
      .rst      (rst),
      .clr      (abort),
      .din      (calc_ing),
      .tap_pre  (lat_pre),
      .tap_last (lat_last)
   );

   assign rd_enable       = calc_ing;
   assign ofmd_wr_addr_en = lat_pre;
   assign ofmd_ram_en     = lat_last || (state == DRAIN) || (state == READ);
   assign ofmd_rd_en      = (state == READ);
   assign ifmd_wr_state   = (state == IF_WR);
   assign kw_wr_state     = (state == KW_WR);
   assign busy            = (state != IDLE);

endmodule

// File: tb/tb_conv_seq_ctrl.sv
// Randomized scoreboard bench: a default-parameter unit checked per frame at out_st,
// plus a minimal-parameter unit (1 bank each, latency 1, 2-bit frame counter).
module tb_conv_seq_ctrl;

   localparam int N_IF = 2, N_KW = 4, PIPE_LAT = 3, CNT_W = 8;

   logic clk = 1'b0;
   always #5 clk = ~clk;
   logic rst;

   logic in_st_ifmd, ifmd_wr_done, in_st_kw, kw_is_5_5, kw_wr_done;
   logic calc_done, ofmd_rd_done, abort, keep_kw;
   logic [N_IF-1:0]  ifmd_ram_en, ifmd_wr;
   logic [N_KW-1:0]  kw_ram_en, kw_wr;
   logic is_5x5, rd_enable, ofmd_wr_addr_en, ofmd_ram_en, ofmd_rd_en, out_st;
   logic ifmd_wr_state, kw_wr_state, busy, err_proto;
   logic [CNT_W-1:0] frame_cnt;

   logic in_st_ifmd_s, ifmd_wr_done_s, in_st_kw_s, kw_is_5_5_s, kw_wr_done_s;
   logic calc_done_s, ofmd_rd_done_s, abort_s, keep_kw_s;
   logic [0:0] ifmd_ram_en_s, ifmd_wr_s, kw_ram_en_s, kw_wr_s;
   logic is_5x5_s, rd_enable_s, ofmd_wr_addr_en_s, ofmd_ram_en_s, ofmd_rd_en_s, out_st_s;
   logic ifmd_wr_state_s, kw_wr_state_s, busy_s, err_proto_s;
   logic [1:0] frame_cnt_s;

   conv_seq_ctrl #(.N_IF(N_IF), .N_KW(N_KW), .PIPE_LAT(PIPE_LAT), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst(rst), .in_st_ifmd(in_st_ifmd), .ifmd_wr_done(ifmd_wr_done),
      .in_st_kw(in_st_kw), .kw_is_5_5(kw_is_5_5), .kw_wr_done(kw_wr_done),
      .calc_done(calc_done), .ofmd_rd_done(ofmd_rd_done), .abort(abort), .keep_kw(keep_kw),
      .ifmd_ram_en(ifmd_ram_en), .ifmd_wr(ifmd_wr), .kw_ram_en(kw_ram_en), .kw_wr(kw_wr),
      .is_5x5(is_5x5), .rd_enable(rd_enable), .ofmd_wr_addr_en(ofmd_wr_addr_en),
      .ofmd_ram_en(ofmd_ram_en), .ofmd_rd_en(ofmd_rd_en), .out_st(out_st),
      .ifmd_wr_state(ifmd_wr_state), .kw_wr_state(kw_wr_state), .busy(busy),
      .frame_cnt(frame_cnt), .err_proto(err_proto));

   conv_seq_ctrl #(.N_IF(1), .N_KW(1), .PIPE_LAT(1), .CNT_W(2)) dut_s (
      .clk(clk), .rst(rst), .in_st_ifmd(in_st_ifmd_s), .ifmd_wr_done(ifmd_wr_done_s),
      .in_st_kw(in_st_kw_s), .kw_is_5_5(kw_is_5_5_s), .kw_wr_done(kw_wr_done_s),
      .calc_done(calc_done_s), .ofmd_rd_done(ofmd_rd_done_s), .abort(abort_s), .keep_kw(keep_kw_s),
      .ifmd_ram_en(ifmd_ram_en_s), .ifmd_wr(ifmd_wr_s), .kw_ram_en(kw_ram_en_s), .kw_wr(kw_wr_s),
      .is_5x5(is_5x5_s), .rd_enable(rd_enable_s), .ofmd_wr_addr_en(ofmd_wr_addr_en_s),
      .ofmd_ram_en(ofmd_ram_en_s), .ofmd_rd_en(ofmd_rd_en_s), .out_st(out_st_s),
      .ifmd_wr_state(ifmd_wr_state_s), .kw_wr_state(kw_wr_state_s), .busy(busy_s),
      .frame_cnt(frame_cnt_s), .err_proto(err_proto_s));

   typedef struct {
      int is5, err, fcnt, kw_cyc, kw_or, if_cyc, if_or, drain, ram_pre;
   } exp_t;

   exp_t sb_q[$];
   int checks = 0, passed = 0;
   bit small_done = 1'b0;

   // Reference model of the default unit, kept at frame granularity.
   int m_kw_loaded = 0, m_keep = 0, m_size = 0, m_err = 0, m_frames = 0;

   task automatic checkOutput(input string name, input longint actual, input longint expected);
      checks++;
      if (actual == expected) passed++;
      else $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Drives one frame on the default unit and pushes its expected summary.
   task automatic applyStimulus(input int calc_len, input bit inject, input bit do_abort,
                                input bit size, input bit keep);
      exp_t e;
      int   w, n;
      int   if_cyc = 0, kw_cyc = 0;
      bit   load_kw;
      load_kw = !(m_kw_loaded != 0 && m_keep != 0);
      for (int b = 0; b < N_IF; b++) begin
         repeat (1 + $urandom_range(0, 2)) tick();
         in_st_ifmd = 1'b1; tick(); in_st_ifmd = 1'b0;
         w = $urandom_range(0, 3);
         repeat (w) tick();
         ifmd_wr_done = 1'b1; tick(); ifmd_wr_done = 1'b0;
         if_cyc += w + 1;
      end
      if (load_kw) begin
         for (int b = 0; b < N_KW; b++) begin
            repeat (1 + $urandom_range(0, 2)) tick();
            kw_is_5_5 = (b == 0) ? size : 1'($urandom_range(0, 1));
            if (b == 0) m_size = size;
            in_st_kw = 1'b1; tick(); in_st_kw = 1'b0;
            if (do_abort && b == 2) begin
               abort = 1'b1; kw_wr_done = 1'b1; tick(); abort = 1'b0; kw_wr_done = 1'b0;
               checkOutput("abort_busy", busy, 0);
               checkOutput("abort_kw_ram_en", kw_ram_en, 0);
               checkOutput("abort_ifmd_ram_en", ifmd_ram_en, 0);
               checkOutput("abort_ofmd_ram_en", ofmd_ram_en, 0);
               checkOutput("abort_err", err_proto, 0);
               checkOutput("abort_is5x5_held", is_5x5, m_size);
               checkOutput("abort_frame_cnt_held", frame_cnt, m_frames % 256);
               m_kw_loaded = 0; m_keep = 0; m_err = 0;
               return;
            end
            w = $urandom_range(0, 3);
            repeat (w) tick();
            kw_wr_done = 1'b1; tick(); kw_wr_done = 1'b0;
            kw_cyc += w + 1;
         end
      end
      for (int c = 1; c < calc_len; c++) begin
         if (inject && c == 2) in_st_kw = 1'b1;
         tick();
         in_st_kw = 1'b0;
      end
      if (inject) m_err = 1;
      e.is5     = m_size;
      e.err     = m_err;
      e.fcnt    = m_frames % 256;
      e.kw_cyc  = kw_cyc;
      e.kw_or   = load_kw ? (1 << N_KW) - 1 : 0;
      e.if_cyc  = if_cyc;
      e.if_or   = (1 << N_IF) - 1;
      e.drain   = PIPE_LAT;
      e.ram_pre = (calc_len > PIPE_LAT) ? calc_len : PIPE_LAT;
      sb_q.push_back(e);
      calc_done = 1'b1; tick(); calc_done = 1'b0;
      keep_kw = keep;
      n = 0;
      while (!ofmd_rd_en && n < 40) begin
         tick();
         n++;
      end
      checkOutput("read_reached", ofmd_rd_en, 1);
      repeat ($urandom_range(0, 3)) tick();
      ofmd_rd_done = 1'b1; tick(); ofmd_rd_done = 1'b0;
      tick();
      m_frames++;
      m_keep = keep;
      if (load_kw) m_kw_loaded = 1;
      checkOutput("frame_cnt", frame_cnt, m_frames % 256);
   endtask

   // Monitor for the default unit: accumulates per-frame activity, scores it at out_st.
   int mon_kw_cyc = 0, mon_kw_or = 0, mon_if_cyc = 0, mon_if_or = 0;
   int mon_drain = 0, mon_ram_pre = 0, mon_lag_err = 0, mon_en_err = 0, mon_hot_err = 0;
   logic [7:0] rd_hist = '0;
   exp_t me;
   always @(negedge clk) begin
      if (rst || !busy) begin
         mon_kw_cyc = 0; mon_kw_or = 0; mon_if_cyc = 0; mon_if_or = 0;
         mon_drain = 0; mon_ram_pre = 0; mon_lag_err = 0; mon_en_err = 0; mon_hot_err = 0;
      end else begin
         if (kw_wr != '0) begin
            mon_kw_cyc++;
            mon_kw_or |= int'(kw_wr);
            if (!$onehot(kw_wr)) mon_hot_err++;
         end
         if (ifmd_wr != '0) begin
            mon_if_cyc++;
            mon_if_or |= int'(ifmd_wr);
            if (!$onehot(ifmd_wr)) mon_hot_err++;
         end
         if (kw_ram_en != (rd_enable ? {N_KW{1'b1}} : kw_wr)) mon_en_err++;
         if (ifmd_ram_en != (rd_enable ? {N_IF{1'b1}} : ifmd_wr)) mon_en_err++;
         if (ifmd_wr_state != (ifmd_wr != '0) || kw_wr_state != (kw_wr != '0)) mon_en_err++;
         if (ofmd_wr_addr_en != rd_hist[PIPE_LAT-2]) mon_lag_err++;
         if (ofmd_ram_en && !rd_enable && !ofmd_rd_en) mon_drain++;
         if (ofmd_ram_en && !ofmd_rd_en) mon_ram_pre++;
         if (out_st) begin
            if (sb_q.size() == 0) begin
               checkOutput("unexpected_out_st", 1, 0);
            end else begin
               me = sb_q.pop_front();
               checkOutput("out_st_with_read", ofmd_rd_en, 1);
               checkOutput("is_5x5", is_5x5, me.is5);
               checkOutput("err_proto", err_proto, me.err);
               checkOutput("frame_cnt_at_out", frame_cnt, me.fcnt);
               checkOutput("kw_wr_cycles", mon_kw_cyc, me.kw_cyc);
               checkOutput("kw_banks", mon_kw_or, me.kw_or);
               checkOutput("ifmd_wr_cycles", mon_if_cyc, me.if_cyc);
               checkOutput("ifmd_banks", mon_if_or, me.if_or);
               checkOutput("drain_cycles", mon_drain, me.drain);
               checkOutput("ofmd_ram_en_cycles", mon_ram_pre, me.ram_pre);
               checkOutput("wr_addr_lag_errors", mon_lag_err, 0);
               checkOutput("ram_en_errors", mon_en_err, 0);
               checkOutput("onehot_errors", mon_hot_err, 0);
            end
            mon_kw_cyc = 0; mon_kw_or = 0; mon_if_cyc = 0; mon_if_or = 0;
            mon_drain = 0; mon_ram_pre = 0; mon_lag_err = 0; mon_en_err = 0; mon_hot_err = 0;
         end
      end
      rd_hist = {rd_hist[6:0], rd_enable};
   end

   // Monitor for the minimal unit.
   int s_lag_err = 0, s_drain = 0, s_drain_last = -1;
   always @(negedge clk) begin
      if (!rst) begin
         if (ofmd_wr_addr_en_s != rd_enable_s) s_lag_err++;
         if (ofmd_ram_en_s && !rd_enable_s && !ofmd_rd_en_s) s_drain++;
         if (out_st_s) begin
            s_drain_last = s_drain;
            s_drain = 0;
         end
      end
   end

   initial begin
      int n;
      wait (small_done == 1'b0 && rst === 1'b0);
      repeat (3) tick();
      for (int f = 1; f <= 5; f++) begin
         kw_is_5_5_s = f[0];
         in_st_ifmd_s = 1'b1; tick(); in_st_ifmd_s = 1'b0;
         tick();
         ifmd_wr_done_s = 1'b1; tick(); ifmd_wr_done_s = 1'b0;
         in_st_kw_s = 1'b1; tick(); in_st_kw_s = 1'b0;
         kw_wr_done_s = 1'b1; tick(); kw_wr_done_s = 1'b0;
         repeat (f + 2) tick();
         calc_done_s = 1'b1; tick(); calc_done_s = 1'b0;
         n = 0;
         while (!ofmd_rd_en_s && n < 20) begin
            tick();
            n++;
         end
         checkOutput("s_read_reached", ofmd_rd_en_s, 1);
         tick();
         ofmd_rd_done_s = 1'b1; tick(); ofmd_rd_done_s = 1'b0;
         tick();
         checkOutput("s_frame_cnt", frame_cnt_s, f % 4);
         checkOutput("s_drain_cycles", s_drain_last, 1);
         checkOutput("s_is_5x5", is_5x5_s, f % 2);
         s_drain_last = -1;
      end
      checkOutput("s_wr_addr_eq_rd_enable", s_lag_err, 0);
      small_done = 1'b1;
   end

   initial begin
      int n;
      rst = 1'b1;
      {in_st_ifmd, ifmd_wr_done, in_st_kw, kw_is_5_5, kw_wr_done} = '0;
      {calc_done, ofmd_rd_done, keep_kw} = '0;
      abort = 1'b1;
      {in_st_ifmd_s, ifmd_wr_done_s, in_st_kw_s, kw_is_5_5_s, kw_wr_done_s} = '0;
      {calc_done_s, ofmd_rd_done_s, abort_s, keep_kw_s} = '0;
      repeat (3) tick();
      checkOutput("rst_busy", busy, 0);
      checkOutput("rst_frame_cnt", frame_cnt, 0);
      checkOutput("rst_is_5x5", is_5x5, 0);
      checkOutput("rst_err", err_proto, 0);
      checkOutput("rst_out_st", out_st, 0);
      checkOutput("rst_ifmd_ram_en", ifmd_ram_en, 0);
      checkOutput("rst_kw_ram_en", kw_ram_en, 0);
      checkOutput("rst_ofmd_ram_en", ofmd_ram_en, 0);
      checkOutput("rst_rd_enable", rd_enable, 0);
      rst = 1'b0;
      abort = 1'b0;
      $display("[TB] reset released");

      applyStimulus(20, 1'b0, 1'b0, 1'b1, 1'b1);
      applyStimulus($urandom_range(3, 25), 1'b0, 1'b0, 1'b0, 1'b0);
      applyStimulus($urandom_range(3, 25), 1'b0, 1'b1, 1'b0, 1'b0);
      applyStimulus($urandom_range(3, 25), 1'b1, 1'b0, 1'b1, 1'b1);
      applyStimulus($urandom_range(3, 25), 1'b0, 1'b0, 1'b0, 1'b1);
      for (int i = 0; i < 8; i++) begin
         applyStimulus($urandom_range(3, 25), $urandom_range(0, 3) == 0,
                       $urandom_range(0, 4) == 0, 1'($urandom_range(0, 1)),
                       1'($urandom_range(0, 1)));
      end

      n = 0;
      while (!small_done && n < 5000) begin
         tick();
         n++;
      end
      checkOutput("small_unit_finished", small_done, 1);
      repeat (2) tick();
      checkOutput("scoreboard_empty", sb_q.size(), 0);
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule

// File: doc/conv_seq_ctrl.md
CONV_SEQ_CTRL -- requirements
Module: conv_seq_ctrl

Interface
REQ-001 Parameters (name, default, meaning), one per line:
  N_IF, 2, input-feature-map RAM banks (1..4)
  N_KW, 4, kernel-weight RAM banks (1..8)
  PIPE_LAT, 3, datapath latency in cycles from rd_enable to output-RAM write (1..8)
  CNT_W, 8, frame counter width
REQ-002 Ports (name direction width meaning):
  clk in 1 clock; one clock, all logic on its rising edge
  rst in 1 reset, synchronous, active-high
  in_st_ifmd in 1 start of one ifmap bank load
  ifmd_wr_done in 1 current ifmap bank load finished
  in_st_kw in 1 start of one kernel bank load
  kw_is_5_5 in 1 kernel size flag, 1=5x5, 0=3x3
  kw_wr_done in 1 current kernel bank load finished
  calc_done in 1 address generator finished
  ofmd_rd_done in 1 result readout finished
  abort in 1 cancel operation, return to IDLE
  keep_kw in 1 reuse loaded kernels for next frame
  ifmd_ram_en out N_IF per-bank ifmap RAM enable
  ifmd_wr out N_IF per-bank ifmap write strobe
  kw_ram_en out N_KW per-bank kernel RAM enable
  kw_wr out N_KW per-bank kernel write strobe
  is_5x5 out 1 latched kernel size
  rd_enable out 1 calculation read enable
  ofmd_wr_addr_en out 1 output-RAM write-address advance
  ofmd_ram_en out 1 output RAM enable
  ofmd_rd_en out 1 result readout enable
  out_st out 1 one-cycle result-ready pulse
  ifmd_wr_state out 1 ifmap load in progress
  kw_wr_state out 1 kernel load in progress
  busy out 1 state not IDLE
  frame_cnt out CNT_W completed frames, wraps
  err_proto out 1 sticky protocol error

Function
REQ-003 States: IDLE, IF_WAIT, IF_WR, KW_WAIT, KW_WR, CALC, DRAIN, READ, DONE; bank index bidx counts banks within a load phase.
REQ-004 IDLE->IF_WR on in_st_ifmd, bidx=0; IF_WAIT->IF_WR on in_st_ifmd.
REQ-005 IF_WR on ifmd_wr_done: bidx<N_IF-1 -> IF_WAIT, bidx+1; else -> KW_WAIT, bidx=0, or -> CALC if kw_valid=1 and keep_kw_q=1.
REQ-006 KW_WAIT->KW_WR on in_st_kw; KW_WR on kw_wr_done: bidx<N_KW-1 -> KW_WAIT, bidx+1; else -> CALC, kw_valid<=1.
REQ-007 CALC->DRAIN on calc_done; DRAIN lasts exactly PIPE_LAT cycles, then READ; READ->DONE on ofmd_rd_done; DONE lasts one cycle, then IF_WAIT, bidx=0, frame_cnt+1 (mod 2^CNT_W).
REQ-008 keep_kw_q samples keep_kw in DONE; cleared by rst or abort.
REQ-009 is_5x5 loads kw_is_5_5 on the cycle state=KW_WAIT, bidx=0, in_st_kw=1; holds otherwise; unchanged when kernel load is skipped.
REQ-010 ifmd_wr[i]=IF_WR&&bidx==i; ifmd_ram_en[i]=ifmd_wr[i]||CALC; kw_wr[i], kw_ram_en[i] likewise for KW_WR.
REQ-011 rd_enable=CALC; ifmd_wr_state=IF_WR; kw_wr_state=KW_WR; busy=state!=IDLE.
REQ-012 calc_ing=CALC feeds a PIPE_LAT-deep shift register d[1..PIPE_LAT]; ofmd_wr_addr_en=d[PIPE_LAT-1] (=CALC when PIPE_LAT=1); ofmd_ram_en=d[PIPE_LAT]||DRAIN||READ.
REQ-013 out_st registered: 1 the cycle after the last DRAIN cycle, coincident with first READ cycle, 0 otherwise.
REQ-014 ofmd_rd_en=READ.
REQ-015 err_proto set when in_st_ifmd or in_st_kw is 1 in IF_WR, KW_WR, CALC, DRAIN or READ; done strobes outside their state are ignored.
REQ-016 abort, any state: next cycle state=IDLE, bidx=0, kw_valid=0, keep_kw_q=0, shift register cleared, out_st=0, err_proto=0; frame_cnt and is_5x5 held; abort wins over all other inputs that cycle.
REQ-017 Simultaneous done strobe and start strobe: done processed, start ignored (no double advance).

Reset
REQ-018 rst=1 at a clk edge: state=IDLE, bidx=0, is_5x5=0, kw_valid=0, keep_kw_q=0, shift register=0, out_st=0, frame_cnt=0, err_proto=0; all combinational outputs 0 consequently; rst overrides abort.

Structure
REQ-019 Package conv_pkg holds the state enumeration and parameter bounds.
REQ-020 One sub-module, conv_lat_pipe (PIPE_LAT shift register with sync clear), instantiated once.

Verification
REQ-021 Defaults, full flow: 2 ifmap, 4 kernel loads, kw_is_5_5=1, calc_done at CALC cycle 20 -> ifmd_wr/kw_wr one-hot per bank, is_5x5=1, DRAIN 3 cycles, out_st single pulse, frame_cnt=1.
REQ-022 Second frame with keep_kw=1 in DONE -> after 2 ifmap loads state goes directly to CALC, kw_wr never asserted, frame_cnt=2.
REQ-023 PIPE_LAT=1, N_IF=1, N_KW=1 -> ofmd_wr_addr_en equals rd_enable, DRAIN 1 cycle.
REQ-024 abort during KW_WR bank 2 -> IDLE next cycle, all enables 0, next frame reloads all kernels.
REQ-025 in_st_kw pulsed during CALC -> err_proto=1 and stays 1 until abort/rst; flow unaffected.
REQ-026 CNT_W=2, 5 frames -> frame_cnt sequence 1,2,3,0,1.
